// File: rtl/activation_lut_scheduler.sv
// rtl/activation_lut_scheduler.sv - round-robin arbiter sharing one LUT read port across requester lanes
// Optional saturating perf counters are built when LUT_SCHED_PERF_CNT_EN is defined.

module activation_lut_scheduler #(
    parameter int DATA_IN_0_PRECISION_0  = 8,
    parameter int DATA_OUT_0_PRECISION_0 = 8,
    parameter int NUM_REQ                = 4
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [NUM_REQ-1:0][DATA_IN_0_PRECISION_0-1:0]      req_data,
    input  logic [NUM_REQ-1:0]                                 req_valid,
    output logic [NUM_REQ-1:0]                                 req_ready,
    output logic [NUM_REQ-1:0][DATA_OUT_0_PRECISION_0-1:0]     rsp_data,
    output logic [NUM_REQ-1:0]                                 rsp_valid,
    input  logic [NUM_REQ-1:0]                                 rsp_ready,
    output logic                                               lut_rd_en,
    output logic [DATA_IN_0_PRECISION_0-1:0]                   lut_rd_addr,
    input  logic [DATA_OUT_0_PRECISION_0-1:0]                  lut_rd_data,
    output logic                                               lut_wr_en,
    output logic [DATA_IN_0_PRECISION_0-1:0]                   lut_wr_addr,
    output logic [DATA_OUT_0_PRECISION_0-1:0]                  lut_wr_data,
    input  logic [DATA_OUT_0_PRECISION_0-1:0]                  load_data,
    input  logic                                               load_valid,
    output logic                                               load_ready,
    input  logic                                               reload_req,
    output logic                                               busy
`ifdef LUT_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]                                        perf_grant_cnt,
    output logic [31:0]                                        perf_stall_cnt
`endif
);

    localparam int AW = DATA_IN_0_PRECISION_0;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [AW-1:0]      load_cnt;
    logic [NUM_REQ-1:0] pending, rsp_hs, fill_vec;
    logic [IW-1:0]      rr_ptr, grant_idx, rd_lane;
    logic               grant_found, rd_inflight, load_hs;
    int                 lane;

    // Combinational strobes are gated by rst so the reset cycle itself is quiet.
    assign load_ready  = (state == LOAD) && !rst;
    assign load_hs     = load_ready && load_valid;
    assign lut_wr_en   = load_hs;
    assign lut_wr_addr = load_cnt;
    assign lut_wr_data = load_data;
    assign busy        = rst || (state != RUN);
    assign rsp_hs      = rsp_valid & rsp_ready;
    assign lut_rd_en   = grant_found;
    assign lut_rd_addr = req_data[grant_idx];

    // Search starts at the lane after the last grant; pending lanes are skipped.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        lane        = 0;
        if (state == RUN && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                lane = (int'(rr_ptr) + k) % NUM_REQ;
                if (!grant_found && req_valid[lane] && !pending[lane]) begin
                    grant_found = 1'b1;
                    grant_idx   = IW'(lane);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        fill_vec  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_found && (grant_idx == IW'(i));
            fill_vec[i]  = rd_inflight && (rd_lane == IW'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (load_hs && (&load_cnt)) state_nxt = RUN;
            RUN:     if (reload_req) state_nxt = DRAIN;
            DRAIN:   if (pending == '0) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            load_cnt    <= '0;
            pending     <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rr_ptr      <= '0;
            rd_inflight <= 1'b0;
            rd_lane     <= '0;
        end else begin
            state <= state_nxt;
            // Counter wraps to zero on the final word of a full load.
            if (load_hs) load_cnt <= load_cnt + 1'b1;
            rd_inflight <= grant_found;
            if (grant_found) begin
                rd_lane <= grant_idx;
                rr_ptr  <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (rd_inflight) rsp_data[rd_lane] <= lut_rd_data;
            pending   <= (pending & ~rsp_hs) | req_ready;
            rsp_valid <= (rsp_valid & ~rsp_hs) | fill_vec;
        end
    end

`ifdef LUT_SCHED_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (grant_found && (perf_grant_cnt != '1))
                perf_grant_cnt <= perf_grant_cnt + 32'd1;
            if ((state == RUN) && (|req_valid) && !grant_found && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/activation_lut_scheduler.md
ACTIVATION_LUT_SCHEDULER -- requirements
Module: activation_lut_scheduler

Interface
REQ-001 SHALL have parameter DATA_IN_0_PRECISION_0, default 8: LUT address width; LUT depth MEM_SIZE = 2**DATA_IN_0_PRECISION_0.
REQ-002 SHALL have parameter DATA_OUT_0_PRECISION_0, default 8: LUT word width.
REQ-003 SHALL have parameter NUM_REQ, default 4: number of requester lanes sharing one LUT read port; legal range 2..16.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports req_data, req_valid and req_ready: req_data is an input array of NUM_REQ x DATA_IN_0_PRECISION_0 (per-lane LUT address); req_valid is input, NUM_REQ; req_ready is output, NUM_REQ.
REQ-007 SHALL have ports rsp_data, rsp_valid and rsp_ready: rsp_data is an output array of NUM_REQ x DATA_OUT_0_PRECISION_0; rsp_valid is output, NUM_REQ; rsp_ready is input, NUM_REQ.
REQ-008 SHALL have LUT read ports: lut_rd_en, output, 1; lut_rd_addr, output, DATA_IN_0_PRECISION_0; lut_rd_data, input, DATA_OUT_0_PRECISION_0, valid exactly 1 cycle after lut_rd_en.
REQ-009 SHALL have LUT write ports: lut_wr_en, output, 1; lut_wr_addr, output, DATA_IN_0_PRECISION_0; lut_wr_data, output, DATA_OUT_0_PRECISION_0.
REQ-010 SHALL have load ports: load_data, input, DATA_OUT_0_PRECISION_0; load_valid, input, 1; load_ready, output, 1; reload_req, input, 1, a level request to re-enter LOAD; busy, output, 1, high in every state except RUN.

Function
REQ-011 SHALL implement FSM states LOAD, RUN and DRAIN; rst forces LOAD.
REQ-012 In LOAD, the block SHALL drive load_ready=1; each load handshake SHALL drive lut_wr_en=1, lut_wr_addr=load counter and lut_wr_data=load_data in the same cycle, then increment the counter.
REQ-013 The handshake at counter MEM_SIZE-1 SHALL clear the counter to 0 and move the FSM to RUN on the next cycle; there SHALL be no partial-load exit.
REQ-014 In RUN, each cycle the block SHALL grant at most one lane i with req_valid[i]=1 and pending[i]=0, chosen round-robin starting from the lane after the last grant; lane 0 SHALL have first priority after reset.
REQ-015 req_ready[i] SHALL be 1 only in the cycle lane i is granted; a grant SHALL drive lut_rd_en=1 with lut_rd_addr=req_data[i] and set pending[i].
REQ-016 One cycle after a grant, lut_rd_data SHALL be captured into rsp_data[i], and rsp_valid[i] SHALL assert on the following cycle; grant-to-rsp_valid latency SHALL be 2 cycles.
REQ-017 rsp_valid[i] and rsp_data[i] SHALL hold until rsp_ready[i]=1; the handshake SHALL clear rsp_valid[i] and pending[i] on the next edge.
REQ-018 A lane SHALL be ineligible in the cycle its response handshakes; back-to-back throughput SHALL be 1 result per 3 cycles per lane and 1 grant per cycle aggregate.
REQ-019 reload_req=1 in RUN SHALL move the FSM to DRAIN; DRAIN SHALL issue no grants and SHALL enter LOAD once all pending bits are 0.
REQ-020 In LOAD and DRAIN, req_ready SHALL be all 0 and lut_rd_en SHALL be 0; lut_wr_en SHALL be 0 outside LOAD.
REQ-021 reload_req asserted in LOAD or DRAIN SHALL be ignored.

Reset
REQ-022 On rst, the block SHALL set state=LOAD, load counter=0, pending=0, rsp_valid=0, rsp_data=0, round-robin pointer to lane 0, req_ready=0, lut_rd_en=0, lut_wr_en=0, load_ready=0 in the reset cycle and busy=1.
REQ-023 rst asserted mid-operation SHALL discard in-flight reads and responses without further output.

Configuration
REQ-024 When macro LUT_SCHED_PERF_CNT_EN is defined, the block SHALL add outputs perf_grant_cnt (32-bit, +1 per grant) and perf_stall_cnt (32-bit, +1 per RUN cycle with any req_valid=1 and no grant), both saturating and cleared by rst; when the macro is undefined, neither port nor counter SHALL exist.

Verification
REQ-025 Load test: after reset, stream MEM_SIZE=256 words, word=address XOR 0x5A -> 256 writes at addresses 0..255, busy falls 1 cycle after the last handshake.
REQ-026 Single-lane test: lane 2 requests address 0x10, rsp_ready=1 -> rsp_data[2]=0x4A, rsp_valid[2] asserted 2 cycles after req_ready[2].
REQ-027 Fairness test: all 4 lanes request continuously with rsp_ready=1 -> grants follow 0,1,2,3,0,... with no lane starved for more than 3 cycles.
REQ-028 Backpressure test: lane 1 rsp_ready=0 for 10 cycles -> rsp_data[1] stable, lane 1 not re-granted, other lanes granted normally.
REQ-029 Reload test: reload_req pulsed with 2 reads pending -> no new grants; LOAD is entered only after both responses handshake.
REQ-030 Reset test: rst asserted mid-load at counter 100 -> counter returns to 0, all outputs are at reset values, and a full 256-word load is required again.
